// File: rtl/traffic_lights_pkg.sv
// traffic_lights_pkg: command encodings and frame FSM states shared by the traffic-light controller and its frame receiver
package traffic_lights_pkg;
   localparam int CMD_SIZE      = 3;
   localparam int CMD_DATA_SIZE = 16;
   typedef enum logic [CMD_SIZE-1:0] {
      CMD_ON           = 3'd0,
      CMD_OFF          = 3'd1,
      CMD_NOTRANSITION = 3'd2,
      CMD_SET_GREEN    = 3'd3,
      CMD_SET_RED      = 3'd4,
      CMD_SET_YELLOW   = 3'd5
   } cmd_type_t;
   typedef enum logic [2:0] {HUNT_S, TYPE_S, DHI_S, DLO_S, CSUM_S} frame_state_t;
endpackage

// File: rtl/traffic_cmd_frame_rx.sv
// traffic_cmd_frame_rx: hunts for header/type/data/checksum frames on a byte stream and emits
// one-cycle command or error pulses for the traffic-light controller
module traffic_cmd_frame_rx
   import traffic_lights_pkg::*;
#(
   parameter logic [7:0] HEADER_BYTE  = 8'hA5,
   parameter int         TIMEOUT_CLK  = 1000,
   parameter int         MAX_CMD_TYPE = 5,
   parameter int         ERR_CNT_W    = 8
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [7:0]               byte_i,
   input  logic                     byte_valid_i,
   output logic [CMD_SIZE-1:0]      cmd_type_o,
   output logic [CMD_DATA_SIZE-1:0] cmd_data_o,
   output logic                     cmd_valid_o,
   output logic                     err_csum_o,
   output logic                     err_type_o,
   output logic                     err_timeout_o,
   output logic [ERR_CNT_W-1:0]     err_cnt_o
);
   localparam int TW = $clog2(TIMEOUT_CLK + 1);
   frame_state_t            r_state, w_state_nxt;
   logic [TW-1:0]           r_tmo_cnt;
   logic [7:0]              r_csum, r_dhi, r_dlo;
   logic [CMD_SIZE-1:0]     r_type, r_cmd_type;
   logic                    r_type_ill;
   logic [CMD_DATA_SIZE-1:0] r_cmd_data;
   logic                    r_cmd_valid, r_err_csum, r_err_type, r_err_timeout;
   logic [ERR_CNT_W-1:0]    r_err_cnt;
   logic                    w_expire, w_good, w_csum_bad, w_type_bad, w_err;
   // Expiry is the TIMEOUT_CLK-th consecutive idle cycle; a byte on that cycle still wins.
   assign w_expire = (r_state != HUNT_S) && !byte_valid_i && (r_tmo_cnt == TW'(TIMEOUT_CLK - 1));
   always_comb begin
      w_state_nxt = r_state;
      w_good      = 1'b0;
      w_csum_bad  = 1'b0;
      w_type_bad  = 1'b0;
      if (w_expire) begin
         w_state_nxt = HUNT_S;
      end else if (byte_valid_i) begin
         case (r_state)
            HUNT_S:  w_state_nxt = (byte_i == HEADER_BYTE) ? TYPE_S : HUNT_S;
            TYPE_S:  w_state_nxt = DHI_S;
            DHI_S:   w_state_nxt = DLO_S;
            DLO_S:   w_state_nxt = CSUM_S;
            CSUM_S: begin
               w_state_nxt = HUNT_S;
               w_csum_bad  = byte_i != r_csum;
               w_type_bad  = !w_csum_bad && r_type_ill;
               w_good      = !w_csum_bad && !r_type_ill;
            end
            default: w_state_nxt = HUNT_S;
         endcase
      end
   end
   assign w_err = w_csum_bad || w_type_bad || w_expire;
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state       <= HUNT_S;
         r_tmo_cnt     <= '0;
         r_csum        <= '0;
         r_dhi         <= '0;
         r_dlo         <= '0;
         r_type        <= '0;
         r_type_ill    <= 1'b0;
         r_cmd_type    <= '0;
         r_cmd_data    <= '0;
         r_cmd_valid   <= 1'b0;
         r_err_csum    <= 1'b0;
         r_err_type    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_tmo_cnt     <= (r_state == HUNT_S || byte_valid_i || w_expire) ? '0 : r_tmo_cnt + 1'b1;
         if (byte_valid_i) r_csum <= (r_state == HUNT_S) ? byte_i : r_csum ^ byte_i;
         if (byte_valid_i && r_state == TYPE_S) begin
            r_type     <= byte_i[CMD_SIZE-1:0];
            r_type_ill <= byte_i > 8'(MAX_CMD_TYPE);
         end
         if (byte_valid_i && r_state == DHI_S) r_dhi <= byte_i;
         if (byte_valid_i && r_state == DLO_S) r_dlo <= byte_i;
         if (w_good) begin
            r_cmd_type <= r_type;
            r_cmd_data <= {r_dhi, r_dlo};
         end
         r_cmd_valid   <= w_good;
         r_err_csum    <= w_csum_bad;
         r_err_type    <= w_type_bad;
         r_err_timeout <= w_expire;
         if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end
   assign cmd_type_o    = r_cmd_type;
   assign cmd_data_o    = r_cmd_data;
   assign cmd_valid_o   = r_cmd_valid;
   assign err_csum_o    = r_err_csum;
   assign err_type_o    = r_err_type;
   assign err_timeout_o = r_err_timeout;
   assign err_cnt_o     = r_err_cnt;
endmodule
